// File: rtl/gpio_apb_irq.sv
// Purpose: APB GPIO slave with synchronised inputs, atomic set/clear/toggle of outputs and edge-detect interrupts.
// Latency: writes land on the access-phase edge, reads are combinational, and a pin edge sets status SYNC_STAGES+1 edges later.
// Backpressure: none, because pready_o is tied high; illegal accesses get pslverr_o and change no state.
module gpio_apb_irq #(
    parameter int GPIO_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              psel_i,
    input  logic              penable_i,
    input  logic [5:0]        paddr_i,
    input  logic              pwrite_i,
    input  logic [31:0]       pwdata_i,
    output logic [31:0]       prdata_o,
    output logic              pready_o,
    output logic              pslverr_o,
    input  logic [GPIO_W-1:0] gpio_i,
    output logic [GPIO_W-1:0] gpio_o,
    output logic [GPIO_W-1:0] gpio_oe,
    output logic              irq_o
);

    // Register offsets
    localparam logic [5:0] A_DIR      = 6'h00;
    localparam logic [5:0] A_OUT      = 6'h04;
    localparam logic [5:0] A_IN       = 6'h08;
    localparam logic [5:0] A_OUT_SET  = 6'h0C;
    localparam logic [5:0] A_OUT_CLR  = 6'h10;
    localparam logic [5:0] A_OUT_TGL  = 6'h14;
    localparam logic [5:0] A_IRQ_EN   = 6'h18;
    localparam logic [5:0] A_IRQ_RISE = 6'h1C;
    localparam logic [5:0] A_IRQ_FALL = 6'h20;
    localparam logic [5:0] A_IRQ_STAT = 6'h24;

    // The suppression counter saturates at SYNC_STAGES+1. That is long enough for the
    // synchroniser and prev flop to fill with the real pin levels after reset.
    localparam int                 CNT_W      = $clog2(SYNC_STAGES + 2);
    localparam logic [CNT_W-1:0]   SUP_CYCLES = CNT_W'(SYNC_STAGES + 1);

    logic [GPIO_W-1:0] r_dir;
    logic [GPIO_W-1:0] r_out;
    logic [GPIO_W-1:0] r_irq_en;
    logic [GPIO_W-1:0] r_irq_rise;
    logic [GPIO_W-1:0] r_irq_fall;
    logic [GPIO_W-1:0] r_irq_stat;
    logic [GPIO_W-1:0] r_sync [SYNC_STAGES];
    logic [GPIO_W-1:0] r_prev;
    logic [CNT_W-1:0]  r_sup_cnt;
    logic              r_irq;

    logic              w_err;
    logic              w_wr;
    logic [GPIO_W-1:0] w_wdat;
    logic [GPIO_W-1:0] w_in;
    logic [GPIO_W-1:0] w_rise;
    logic [GPIO_W-1:0] w_fall;
    logic [GPIO_W-1:0] w_evt;
    logic [GPIO_W-1:0] w_stat_clr;
    logic [GPIO_W-1:0] w_rd_dat;
    logic              w_edge_ok;
    logic              w_unused;

    // Error response. Accesses are flagged if they are misaligned, fall beyond the last
    // register, or write to the read-only IN register.
    assign w_err = psel_i & penable_i &
                   ((paddr_i[1:0] != 2'b00) | (paddr_i > A_IRQ_STAT) |
                    (pwrite_i & (paddr_i == A_IN)));

    assign w_wr      = psel_i & penable_i & pwrite_i & ~w_err;
    assign w_wdat    = pwdata_i[GPIO_W-1:0];
    // Upper data bits beyond GPIO_W are deliberately ignored.
    assign w_unused  = ^pwdata_i;

    assign pslverr_o = w_err;
    assign pready_o  = 1'b1;
    assign gpio_o    = r_out;
    assign gpio_oe   = r_dir;
    assign irq_o     = r_irq;

    // Edge detection runs on synchronised data. Events are gated until the post-reset
    // settling window has passed.
    assign w_in       = r_sync[SYNC_STAGES-1];
    assign w_edge_ok  = (r_sup_cnt == SUP_CYCLES);
    assign w_rise     = w_in & ~r_prev;
    assign w_fall     = ~w_in & r_prev;
    assign w_evt      = w_edge_ok ? ((w_rise & r_irq_rise) | (w_fall & r_irq_fall)) : '0;
    assign w_stat_clr = (w_wr && (paddr_i == A_IRQ_STAT)) ? w_wdat : '0;

    // Input synchroniser chain and one-cycle delayed copy used for edge detection
    always_ff @(posedge pclk) begin
        if (preset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_prev <= '0;
        end else begin
            r_sync[0] <= gpio_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= w_in;
        end
    end

    // Post-reset edge suppression counter, saturating
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_sup_cnt <= '0;
        end else if (r_sup_cnt != SUP_CYCLES) begin
            r_sup_cnt <= r_sup_cnt + 1'b1;
        end
    end

    // Control registers and atomic OUT updates, committed in the access phase
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_dir      <= '0;
            r_out      <= '0;
            r_irq_en   <= '0;
            r_irq_rise <= '0;
            r_irq_fall <= '0;
        end else if (w_wr) begin
            case (paddr_i)
                A_DIR:      r_dir      <= w_wdat;
                A_OUT:      r_out      <= w_wdat;
                A_OUT_SET:  r_out      <= r_out | w_wdat;
                A_OUT_CLR:  r_out      <= r_out & ~w_wdat;
                A_OUT_TGL:  r_out      <= r_out ^ w_wdat;
                A_IRQ_EN:   r_irq_en   <= w_wdat;
                A_IRQ_RISE: r_irq_rise <= w_wdat;
                A_IRQ_FALL: r_irq_fall <= w_wdat;
                default:    ;
            endcase
        end
    end

    // Sticky status. A new event in the same cycle as a W1C keeps the bit set.
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_irq_stat <= '0;
        end else begin
            r_irq_stat <= (r_irq_stat & ~w_stat_clr) | w_evt;
        end
    end

    // Registered interrupt level from pending, enabled status
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |(r_irq_stat & r_irq_en);
        end
    end

    // Combinational read mux. Write-only and unmapped offsets read as zero.
    always_comb begin
        w_rd_dat = '0;
        if (psel_i && !pwrite_i) begin
            case (paddr_i)
                A_DIR:      w_rd_dat = r_dir;
                A_OUT:      w_rd_dat = r_out;
                A_IN:       w_rd_dat = w_in;
                A_IRQ_EN:   w_rd_dat = r_irq_en;
                A_IRQ_RISE: w_rd_dat = r_irq_rise;
                A_IRQ_FALL: w_rd_dat = r_irq_fall;
                A_IRQ_STAT: w_rd_dat = r_irq_stat;
                default:    w_rd_dat = '0;
            endcase
        end
    end

    // Zero-extend read data onto the 32-bit bus
    always_comb begin
        prdata_o = '0;
        prdata_o[GPIO_W-1:0] = w_rd_dat;
    end

endmodule

// File: tb/tb_gpio_apb_irq.sv
module tb_gpio_apb_irq;

    logic        pclk;
    logic        preset;
    logic        psel_i;
    logic        penable_i;
    logic [5:0]  paddr_i;
    logic        pwrite_i;
    logic [31:0] pwdata_i;
    logic [31:0] prdata_o;
    logic        pready_o;
    logic        pslverr_o;
    logic [7:0]  gpio_i;
    logic [7:0]  gpio_o;
    logic [7:0]  gpio_oe;
    logic        irq_o;

    int          checks;
    int          errors;
    logic [31:0] rd;
    logic        err;
    logic [5:0]  offs [10];

    gpio_apb_irq #(.GPIO_W(8), .SYNC_STAGES(2)) dut (
        .pclk      (pclk),
        .preset    (preset),
        .psel_i    (psel_i),
        .penable_i (penable_i),
        .paddr_i   (paddr_i),
        .pwrite_i  (pwrite_i),
        .pwdata_i  (pwdata_i),
        .prdata_o  (prdata_o),
        .pready_o  (pready_o),
        .pslverr_o (pslverr_o),
        .gpio_i    (gpio_i),
        .gpio_o    (gpio_o),
        .gpio_oe   (gpio_oe),
        .irq_o     (irq_o)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    // Setup then access phase. It returns just after the commit edge.
    task automatic apb_write(input logic [5:0] a, input logic [31:0] d, output logic e);
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1; paddr_i = a; pwdata_i = d;
        @(posedge pclk); #1;
        penable_i = 1'b1;
        #1 e = pslverr_o;
        @(posedge pclk); #1;
        psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
    endtask

    task automatic apb_read(input logic [5:0] a, output logic [31:0] d, output logic e);
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = a;
        @(posedge pclk); #1;
        penable_i = 1'b1;
        #1 d = prdata_o; e = pslverr_o;
        @(posedge pclk); #1;
        psel_i = 1'b0; penable_i = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0;
        offs = '{6'h00, 6'h04, 6'h08, 6'h0C, 6'h10, 6'h14, 6'h18, 6'h1C, 6'h20, 6'h24};
        preset = 1'b1; psel_i = 1'b0; penable_i = 1'b0; paddr_i = '0;
        pwrite_i = 1'b0; pwdata_i = '0; gpio_i = 8'h00;
        tick(3);
        preset = 1'b0;

        // Reset state: every offset reads zero with a clean response
        for (int i = 0; i < 10; i++) begin
            apb_read(offs[i], rd, err);
            chk($sformatf("reset_rd_%02h", offs[i]), rd, 32'h0);
            chk($sformatf("reset_err_%02h", offs[i]), {31'b0, err}, 32'h0);
        end
        chk("reset_pready", {31'b0, pready_o}, 32'h1);
        chk("reset_gpio_oe", {24'b0, gpio_oe}, 32'h0);
        chk("reset_gpio_o", {24'b0, gpio_o}, 32'h0);
        chk("reset_irq", {31'b0, irq_o}, 32'h0);

        // Output walk: DIR, OUT, then atomic set/clear/toggle
        apb_write(6'h00, 32'hFF, err);
        chk("dir_err", {31'b0, err}, 32'h0);
        chk("dir_oe", {24'b0, gpio_oe}, 32'hFF);
        apb_write(6'h04, 32'h0F, err);
        chk("out_wr", {24'b0, gpio_o}, 32'h0F);
        apb_write(6'h0C, 32'h30, err);
        chk("out_set", {24'b0, gpio_o}, 32'h3F);
        apb_write(6'h10, 32'h01, err);
        chk("out_clr", {24'b0, gpio_o}, 32'h3E);
        apb_write(6'h14, 32'h81, err);
        chk("out_tgl", {24'b0, gpio_o}, 32'hBF);
        apb_read(6'h04, rd, err);
        chk("out_rd", rd, 32'hBF);
        apb_read(6'h0C, rd, err);
        chk("set_rd_zero", rd, 32'h0);
        apb_read(6'h00, rd, err);
        chk("dir_rd", rd, 32'hFF);

        // Synchroniser latency: IN follows the pins two edges later
        gpio_i = 8'h5A;
        psel_i = 1'b1; pwrite_i = 1'b0; penable_i = 1'b0; paddr_i = 6'h08;
        tick(1);
        chk("in_after_1", prdata_o, 32'h00);
        tick(1);
        chk("in_after_2", prdata_o, 32'h5A);
        psel_i = 1'b0;
        gpio_i = 8'h00;
        tick(5);

        // Interrupt setup and edge capture
        apb_write(6'h18, 32'h03, err);
        apb_write(6'h1C, 32'h01, err);
        apb_write(6'h20, 32'h02, err);
        chk("irq_idle", {31'b0, irq_o}, 32'h0);
        gpio_i = 8'h01; tick(5);
        gpio_i = 8'h03; tick(5);
        gpio_i = 8'h01; tick(5);
        gpio_i = 8'h00; tick(5);
        apb_read(6'h24, rd, err);
        chk("stat_both", rd, 32'h03);
        chk("irq_both", {31'b0, irq_o}, 32'h1);
        apb_write(6'h24, 32'h01, err);
        apb_read(6'h24, rd, err);
        chk("stat_w1c0", rd, 32'h02);
        chk("irq_after_w1c0", {31'b0, irq_o}, 32'h1);
        apb_write(6'h24, 32'h02, err);
        chk("irq_commit_edge", {31'b0, irq_o}, 32'h1);
        tick(1);
        chk("irq_cleared", {31'b0, irq_o}, 32'h0);
        apb_read(6'h24, rd, err);
        chk("stat_empty", rd, 32'h00);

        // Same-cycle race: W1C commits on the edge the pin0 rise is captured
        gpio_i = 8'h01; tick(5);
        gpio_i = 8'h00; tick(5);
        apb_read(6'h24, rd, err);
        chk("race_pre", rd, 32'h01);
        gpio_i = 8'h01;
        tick(1);
        apb_write(6'h24, 32'h01, err);
        apb_read(6'h24, rd, err);
        chk("race_set_wins", rd, 32'h01);

        // Illegal accesses: error flagged, nothing changes
        apb_write(6'h08, 32'hFF, err);
        chk("err_wr_in", {31'b0, err}, 32'h1);
        apb_write(6'h26, 32'hFF, err);
        chk("err_wr_26", {31'b0, err}, 32'h1);
        apb_write(6'h28, 32'hFF, err);
        chk("err_wr_28", {31'b0, err}, 32'h1);
        apb_read(6'h28, rd, err);
        chk("err_rd_28", {31'b0, err}, 32'h1);
        apb_read(6'h00, rd, err);
        chk("err_dir_kept", rd, 32'hFF);
        chk("err_ok_resp", {31'b0, err}, 32'h0);
        apb_read(6'h04, rd, err);
        chk("err_out_kept", rd, 32'hBF);
        apb_read(6'h24, rd, err);
        chk("err_stat_kept", rd, 32'h01);
        apb_read(6'h08, rd, err);
        chk("in_rd_pin0", rd, 32'h01);

        // Reset during an access phase aborts the write; high pins out of reset raise no edge
        psel_i = 1'b1; pwrite_i = 1'b1; penable_i = 1'b0; paddr_i = 6'h04; pwdata_i = 32'hAA;
        tick(1);
        penable_i = 1'b1; preset = 1'b1; gpio_i = 8'hFF;
        tick(1);
        psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0; preset = 1'b0;
        apb_write(6'h1C, 32'hFF, err);
        tick(8);
        apb_read(6'h24, rd, err);
        chk("sup_stat_zero", rd, 32'h00);
        apb_read(6'h1C, rd, err);
        chk("sup_rise_set", rd, 32'hFF);
        apb_read(6'h04, rd, err);
        chk("abort_out_zero", rd, 32'h00);
        apb_read(6'h08, rd, err);
        chk("sup_in_high", rd, 32'hFF);
        chk("abort_gpio_o", {24'b0, gpio_o}, 32'h00);
        chk("sup_irq", {31'b0, irq_o}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
